// File: rtl/sweep_gen.sv
// ============================================================================
// Module   : sweep_gen
// Purpose  : Programmable frequency-sweep controller. Produces the phase-
//            increment word for the dds core as a linear up-sweep, a
//            sawtooth repeat or a triangle up/down chirp, stepped at a
//            programmable tick rate.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sweep_gen #(
   parameter int FW = 18,
   parameter int DW = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          stop,
   input  logic [1:0]    mode,
   input  logic [FW-1:0] f_start,
   input  logic [FW-1:0] f_stop,
   input  logic [FW-1:0] step,
   input  logic [DW-1:0] div,
   output logic [FW-1:0] freq,
   output logic          busy,
   output logic          dir,
   output logic          done,
   output logic          wrap
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      UP   = 2'd1,
      DOWN = 2'd2
   } state_t;

   state_t        state;
   logic [FW-1:0] fs_q;
   logic [FW-1:0] fe_q;
   logic [FW-1:0] step_q;
   logic [DW-1:0] div_q;
   logic [1:0]    mode_q;
   logic [DW-1:0] cnt;

   logic          tick;
   logic          saw;
   logic          tri_mode;
   logic [FW:0]   sum;
   logic [FW:0]   diff;
   logic [FW-1:0] up_next;
   logic [FW-1:0] down_next;

   // Tick detection and the clamped next-frequency candidates, computed one
   // bit wider than the word so neither direction can wrap around.
   always_comb begin
      tick      = (state != IDLE) && (cnt == '0);
      saw       = (mode_q == 2'd1);
      tri_mode  = (mode_q == 2'd2);
      sum       = {1'b0, freq} + {1'b0, step_q};
      diff      = {1'b0, freq} - {1'b0, step_q};
      up_next   = (sum > {1'b0, fe_q}) ? fe_q : sum[FW-1:0];
      down_next = (diff[FW] || (diff[FW-1:0] < fs_q)) ? fs_q : diff[FW-1:0];
   end

   // Sweep state machine with registered outputs; stop always takes priority.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         freq   <= '0;
         busy   <= 1'b0;
         dir    <= 1'b0;
         done   <= 1'b0;
         wrap   <= 1'b0;
         cnt    <= '0;
         fs_q   <= '0;
         fe_q   <= '0;
         step_q <= '0;
         div_q  <= '0;
         mode_q <= 2'd0;
      end else begin
         done <= 1'b0;
         wrap <= 1'b0;
         case (state)
            IDLE: begin
               if (start && !stop) begin
                  fs_q   <= f_start;
                  fe_q   <= f_stop;
                  step_q <= step;
                  div_q  <= div;
                  mode_q <= mode;
                  freq   <= f_start;
                  if (f_start < f_stop) begin
                     state <= UP;
                     busy  <= 1'b1;
                     dir   <= 1'b0;
                     cnt   <= div;
                  end else begin
                     done <= 1'b1;
                  end
               end
            end
            default: begin
               if (stop) begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  dir   <= 1'b0;
                  done  <= 1'b1;
                  cnt   <= '0;
               end else begin
                  cnt <= tick ? div_q : cnt - 1'b1;
                  if (tick) begin
                     if (state == UP) begin
                        if (saw && (freq == fe_q)) begin
                           // Sawtooth restart: this tick returns to the floor.
                           freq <= fs_q;
                           wrap <= 1'b1;
                        end else begin
                           freq <= up_next;
                           if (up_next == fe_q) begin
                              if (tri_mode) begin
                                 state <= DOWN;
                                 dir   <= 1'b1;
                                 wrap  <= 1'b1;
                              end else if (!saw) begin
                                 state <= IDLE;
                                 busy  <= 1'b0;
                                 done  <= 1'b1;
                                 cnt   <= '0;
                              end
                           end
                        end
                     end else begin
                        freq <= down_next;
                        if (down_next == fs_q) begin
                           state <= UP;
                           dir   <= 1'b0;
                           wrap  <= 1'b1;
                        end
                     end
                  end
               end
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_sweep_gen.sv
// ============================================================================
// Module   : tb_sweep_gen
// Purpose  : Self-checking bench for sweep_gen with a tick-level reference
//            model of the chirp trajectory.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sweep_gen;
   localparam int FW = 18;
   localparam int DW = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic          stop;
   logic [1:0]    mode;
   logic [FW-1:0] f_start;
   logic [FW-1:0] f_stop;
   logic [FW-1:0] step;
   logic [DW-1:0] div;
   logic [FW-1:0] freq;
   logic          busy;
   logic          dir;
   logic          done;
   logic          wrap;

   sweep_gen #(.FW(FW), .DW(DW)) dut (
      .clk(clk), .rst(rst), .start(start), .stop(stop), .mode(mode),
      .f_start(f_start), .f_stop(f_stop), .step(step), .div(div),
      .freq(freq), .busy(busy), .dir(dir), .done(done), .wrap(wrap)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model state: expected outputs plus latched configuration.
   logic [FW-1:0] m_freq;
   bit            m_busy, m_dir, m_done, m_wrap;
   int            m_cyc;
   int            c_mode, c_fs, c_fe, c_st, c_dv;

   wire [FW+3:0] got = {freq, busy, dir, done, wrap};

   function automatic logic [FW+3:0] expv();
      return {m_freq, m_busy, m_dir, m_done, m_wrap};
   endfunction

   task automatic clk_step();
      @(posedge clk);
      #1;
   endtask

   task automatic scramble_cfg();
      mode    = 2'($urandom_range(0, 3));
      f_start = FW'($urandom);
      f_stop  = FW'($urandom);
      step    = FW'($urandom);
      div     = DW'($urandom_range(0, 7));
   endtask

   // One tick of the chirp, from the frequency-plan rules.
   task automatic model_tick();
      int f, nf;
      f = int'(m_freq);
      if (!m_dir) begin
         if (c_mode == 1 && f == c_fe) begin
            m_freq = FW'(c_fs);
            m_wrap = 1;
         end else begin
            nf = f + c_st;
            if (nf > c_fe) nf = c_fe;
            m_freq = FW'(nf);
            if (nf == c_fe) begin
               if (c_mode == 2) begin
                  m_dir  = 1;
                  m_wrap = 1;
               end else if (c_mode == 0) begin
                  m_busy = 0;
                  m_done = 1;
               end
            end
         end
      end else begin
         nf = f - c_st;
         if (nf < c_fs) nf = c_fs;
         m_freq = FW'(nf);
         if (nf == c_fs) begin
            m_dir  = 0;
            m_wrap = 1;
         end
      end
   endtask

   // Issue a start with the given configuration and set the model accordingly.
   task automatic launch(input int md, input int fs, input int fe, input int st, input int dv);
      mode    = 2'(md);
      f_start = FW'(fs);
      f_stop  = FW'(fe);
      step    = FW'(st);
      div     = DW'(dv);
      start   = 1'b1;
      clk_step();
      start   = 1'b0;
      scramble_cfg();
      c_mode  = (md == 3) ? 0 : md;
      c_fs = fs; c_fe = fe; c_st = st; c_dv = dv;
      m_freq = FW'(fs);
      m_busy = (fs < fe);
      m_done = (fs >= fe);
      m_dir  = 0;
      m_wrap = 0;
      m_cyc  = 0;
   endtask

   // Advance one clock with optional stop/start requests and update the model.
   task automatic cycle(input bit do_stop, input bit do_start);
      stop  = do_stop;
      start = do_start;
      if (do_start) scramble_cfg();
      clk_step();
      stop  = 1'b0;
      start = 1'b0;
      m_done = 0;
      m_wrap = 0;
      if (!m_busy) return;
      if (do_stop) begin
         m_busy = 0;
         m_dir  = 0;
         m_done = 1;
         return;
      end
      m_cyc++;
      if (m_cyc % (c_dv + 1) == 0) model_tick();
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; stop = 1'b0;
      scramble_cfg();
      m_freq = '0; m_busy = 0; m_dir = 0; m_done = 0; m_wrap = 0;
      clk_step(); clk_step();
      rst = 1'b0;
      clk_step();
      n_tests++;
      if (got !== expv()) begin
         n_fail++; $display("FAIL reset_state got=%h exp=%h", got, expv());
      end
      launch(0, 'h200, 'h400, 'h100, 0);
      cycle(0, 0);
      n_tests++;
      if (freq !== 18'h00300 || busy !== 1'b1) begin
         n_fail++; $display("FAIL reset_presweep got freq=%h busy=%b exp freq=00300 busy=1", freq, busy);
      end
      #2 rst = 1'b1;
      #1;
      n_tests++;
      if (got !== '0) begin
         n_fail++; $display("FAIL reset_async got=%h exp=0", got);
      end
      clk_step();
      rst = 1'b0;
      m_freq = '0; m_busy = 0; m_dir = 0; m_done = 0; m_wrap = 0;
      for (int i = 0; i < 4; i++) begin
         cycle(0, 0);
         n_tests++;
         if (got !== expv()) begin
            n_fail++; $display("FAIL reset_release cyc=%0d got=%h exp=%h", i, got, expv());
         end
      end
   endtask

   task automatic test_single();
      launch(0, 'h100, 'h140, 'h10, 3);
      n_tests++;
      if (got !== expv()) begin
         n_fail++; $display("FAIL single_first got=%h exp=%h", got, expv());
      end
      for (int i = 0; i < 100 && m_busy; i++) begin
         cycle(0, 0);
         n_tests++;
         if (got !== expv()) begin
            n_fail++; $display("FAIL single cyc=%0d got=%h exp=%h", i, got, expv());
         end
      end
      n_tests++;
      if (m_busy || freq !== 18'h00140) begin
         n_fail++; $display("FAIL single_end got freq=%h exp freq=00140 idle", freq);
      end
      cycle(0, 0);
      n_tests++;
      if (got !== expv()) begin
         n_fail++; $display("FAIL single_after got=%h exp=%h", got, expv());
      end
   endtask

   task automatic test_clamp();
      launch(0, 'h3FF00, 'h3FFFF, 'h80, 0);
      for (int i = 0; i < 10 && m_busy; i++) begin
         cycle(0, 0);
         n_tests++;
         if (got !== expv()) begin
            n_fail++; $display("FAIL clamp cyc=%0d got=%h exp=%h", i, got, expv());
         end
      end
      n_tests++;
      if (m_busy || freq !== 18'h3FFFF) begin
         n_fail++; $display("FAIL clamp_end got freq=%h exp freq=3ffff idle", freq);
      end
   endtask

   task automatic test_sawtooth();
      launch(1, 'h0, 'h30, 'h10, 0);
      for (int i = 0; i < 13; i++) begin
         cycle(0, 0);
         n_tests++;
         if (got !== expv()) begin
            n_fail++; $display("FAIL sawtooth cyc=%0d got=%h exp=%h", i, got, expv());
         end
      end
      cycle(1, 0);
      n_tests++;
      if (got !== expv()) begin
         n_fail++; $display("FAIL sawtooth_stop got=%h exp=%h", got, expv());
      end
   endtask

   task automatic test_triangle();
      launch(2, 'h10, 'h30, 'h10, 1);
      for (int i = 0; i < 11; i++) begin
         cycle(0, 0);
         n_tests++;
         if (got !== expv()) begin
            n_fail++; $display("FAIL triangle cyc=%0d got=%h exp=%h", i, got, expv());
         end
      end
      cycle(1, 0);
      n_tests++;
      if (got !== expv()) begin
         n_fail++; $display("FAIL triangle_stop got=%h exp=%h", got, expv());
      end
      cycle(0, 0);
      n_tests++;
      if (got !== expv()) begin
         n_fail++; $display("FAIL triangle_idle got=%h exp=%h", got, expv());
      end
   endtask

   task automatic test_degenerate();
      launch(0, 'h50, 'h50, 'h10, 0);
      n_tests++;
      if (got !== {18'h00050, 4'b0010}) begin
         n_fail++; $display("FAIL degenerate got=%h exp=%h", got, {18'h00050, 4'b0010});
      end
      cycle(0, 0);
      n_tests++;
      if (got !== expv()) begin
         n_fail++; $display("FAIL degenerate_after got=%h exp=%h", got, expv());
      end
      cycle(1, 0);
      n_tests++;
      if (got !== expv()) begin
         n_fail++; $display("FAIL idle_stop got=%h exp=%h", got, expv());
      end
   endtask

   task automatic test_conflict();
      launch(1, 'h1000, 'h2000, 'h10, 2);
      for (int i = 0; i < 5; i++) cycle(0, 0);
      cycle(1, 1);
      n_tests++;
      if (got !== expv() || done !== 1'b1) begin
         n_fail++; $display("FAIL conflict_busy got=%h exp=%h", got, expv());
      end
      cycle(1, 1);
      n_tests++;
      if (got !== expv()) begin
         n_fail++; $display("FAIL conflict_idle got=%h exp=%h", got, expv());
      end
   endtask

   task automatic test_start_busy();
      launch(0, 'h100, 'h200, 'h20, 1);
      for (int i = 0; i < 100 && m_busy; i++) begin
         cycle(0, 1);
         n_tests++;
         if (got !== expv()) begin
            n_fail++; $display("FAIL start_busy cyc=%0d got=%h exp=%h", i, got, expv());
         end
      end
      n_tests++;
      if (m_busy || freq !== 18'h00200) begin
         n_fail++; $display("FAIL start_busy_end got freq=%h exp freq=00200 idle", freq);
      end
   endtask

   task automatic test_random();
      int md, fs, fe, st, dv, stop_at;
      for (int it = 0; it < 20; it++) begin
         md = $urandom_range(0, 3);
         fs = $urandom_range(0, 'h3F000);
         fe = fs + 1 + $urandom_range(0, 'h3FF);
         st = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(8, 'h200);
         dv = $urandom_range(0, 3);
         stop_at = (md == 1 || md == 2 || st == 0) ? $urandom_range(3, 150) : -1;
         launch(md, fs, fe, st, dv);
         for (int i = 0; i < 5000 && m_busy; i++) begin
            cycle(i == stop_at, 0);
            n_tests++;
            if (got !== expv()) begin
               n_fail++;
               $display("FAIL random it=%0d cyc=%0d got=%h exp=%h", it, i, got, expv());
            end
         end
         n_tests++;
         if (m_busy) begin
            n_fail++; $display("FAIL random_timeout it=%0d busy=%b exp busy=0", it, busy);
            cycle(1, 0);
         end
         cycle(0, 0);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_clamp();
      test_sawtooth();
      test_triangle();
      test_degenerate();
      test_conflict();
      test_start_busy();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
